// File: rtl/tisc_pkg.sv
// tisc_pkg: opcodes, issue FSM states, instruction field positions and opcode classifiers.
package tisc_pkg;
  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_LS    = 4'b0100;
  localparam logic [3:0] OP_CMP   = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam int OP_POS  = 12;
  localparam int RD_POS  = 8;
  localparam int RS1_POS = 4;
  localparam int RS2_POS = 0;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SETTLE, S_EXEC, S_MEMWAIT, S_HALT
  } state_e;
  function automatic logic is_mem_op(input logic [3:0] op);
    return op == OP_LOAD || op == OP_STORE;
  endfunction
  function automatic logic is_illegal(input logic [3:0] op);
    return op >= 4'b0110 && op <= 4'b1110;
  endfunction
endpackage

// File: rtl/instr_issue_unit.sv
// instr_issue_unit: fetches instructions, splits fields, drives the CU opcode and strobes exec_valid.
module instr_issue_unit
  import tisc_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [3:0]        opcode,
  output logic [3:0]        rd_addr,
  output logic [3:0]        rs1_addr,
  output logic [3:0]        rs2_addr,
  output logic              exec_valid,
  input  logic              dmem_done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [3:0] op_q, op_d, rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic illegal_q, illegal_d;
  logic [3:0] ir_op;
  assign ir_op = ir_q[OP_POS +: 4];
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:    state_d = start ? S_FETCH : S_IDLE;
      S_FETCH: if (imem_ack) begin
        ir_d    = imem_data;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d      = ir_op;
        rd_d      = ir_q[RD_POS +: 4];
        rs1_d     = ir_q[RS1_POS +: 4];
        rs2_d     = ir_q[RS2_POS +: 4];
        illegal_d = illegal_q | is_illegal(ir_op);
        state_d   = (ir_op == OP_HALT || is_illegal(ir_op)) ? S_HALT : S_SETTLE;
      end
      S_SETTLE:  state_d = S_EXEC;
      S_EXEC:    state_d = (is_mem_op(op_q) && !dmem_done) ? S_MEMWAIT : S_FETCH;
      S_MEMWAIT: state_d = dmem_done ? S_FETCH : S_MEMWAIT;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      op_q      <= OP_HALT;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      illegal_q <= illegal_d;
    end
  end
  assign imem_req   = state_q == S_FETCH;
  assign imem_addr  = pc_q;
  assign exec_valid = state_q == S_EXEC;
  assign halted     = state_q == S_HALT;
  assign illegal    = illegal_q;
  assign pc         = pc_q;
  assign opcode     = op_q;
  assign rd_addr    = rd_q;
  assign rs1_addr   = rs1_q;
  assign rs2_addr   = rs2_q;
endmodule

// File: tb/tb_instr_issue_unit.sv
// tb_instr_issue_unit: table-driven issue checks with an expected-result queue, plus halt/illegal/reset/wrap sequences.
module tb_instr_issue_unit;
  logic clk = 1'b0;
  logic rst_n, start, imem_ack, dmem_done;
  logic [15:0] imem_data;
  logic imem_req, exec_valid, halted, illegal;
  logic [7:0] imem_addr, pc;
  logic [3:0] opcode, rd_addr, rs1_addr, rs2_addr;
  logic start4, req4, ack4, ev4, halted4, illegal4;
  logic [15:0] data4;
  logic [3:0] addr4, pc4, op4, rd4, rs14, rs24;
  logic dmem4;
  int n_cmp = 0, n_err = 0, cyc = 0, t0 = 0;
  typedef struct {
    logic [3:0] op, rd, rs1, rs2;
    logic [7:0] pc;
  } exp_t;
  typedef struct {
    logic [15:0] ins;
    int dly;
    logic dmem;
    exp_t e;
  } vec_t;
  exp_t sb[$];
  vec_t vt[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_issue_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .opcode(opcode), .rd_addr(rd_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .exec_valid(exec_valid), .dmem_done(dmem_done),
    .pc(pc), .halted(halted), .illegal(illegal)
  );

  assign ack4 = req4;
  assign data4 = 16'h2123;
  assign dmem4 = 1'b0;
  instr_issue_unit #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .imem_req(req4), .imem_addr(addr4),
    .imem_ack(ack4), .imem_data(data4), .opcode(op4), .rd_addr(rd4),
    .rs1_addr(rs14), .rs2_addr(rs24), .exec_valid(ev4), .dmem_done(dmem4),
    .pc(pc4), .halted(halted4), .illegal(illegal4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_opcode"}, 32'(opcode), 32'hF);
    chk({tag, "_fields"}, 32'({rd_addr, rs1_addr, rs2_addr}), 32'h0);
    chk({tag, "_pc"}, 32'(pc), 32'h0);
    chk({tag, "_strobes"}, 32'({imem_req, exec_valid, halted, illegal}), 32'h0);
  endtask

  task automatic serve_fetch(input logic [15:0] ins, input int dly, input logic [7:0] exp_addr);
    int n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    chk("fetch_req", 32'(imem_req), 32'h1);
    t0 = cyc;
    chk("fetch_addr", 32'(imem_addr), 32'(exp_addr));
    for (int i = 0; i < dly; i++) begin
      imem_ack = 1'b0;
      imem_data = 16'h5555;
      tick();
      chk("req_hold", 32'(imem_req), 32'h1);
      chk("addr_hold", 32'(imem_addr), 32'(exp_addr));
    end
    imem_ack = 1'b1;
    imem_data = ins;
    tick();
    imem_ack = 1'b0;
    imem_data = 16'h5555;
  endtask

  task automatic wait_exec(input int exp_lat, input logic done_now);
    int n = 0;
    exp_t e;
    while (!exec_valid && n < 20) begin tick(); n++; end
    chk("exec_seen", 32'(exec_valid), 32'h1);
    if (exec_valid) begin
      chk("latency", 32'(cyc - t0), 32'(exp_lat));
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: exec_valid with no expected instruction");
      end else begin
        e = sb.pop_front();
        chk("opcode", 32'(opcode), 32'(e.op));
        chk("rd", 32'(rd_addr), 32'(e.rd));
        chk("rs1", 32'(rs1_addr), 32'(e.rs1));
        chk("rs2", 32'(rs2_addr), 32'(e.rs2));
        chk("pc", 32'(pc), 32'(e.pc));
      end
      dmem_done = done_now;
      tick();
      dmem_done = 1'b0;
      chk("exec_pulse", 32'(exec_valid), 32'h0);
    end
  endtask

  initial begin
    logic [3:0] prev;
    logic seen;
    vt[0] = '{16'h2123, 0, 1'b0, '{4'h2, 4'h1, 4'h2, 4'h3, 8'd1}};
    vt[1] = '{16'h3456, 0, 1'b1, '{4'h3, 4'h4, 4'h5, 4'h6, 8'd2}};
    vt[2] = '{16'h0A5F, 0, 1'b1, '{4'h0, 4'hA, 4'h5, 4'hF, 8'd3}};
    vt[3] = '{16'h19C7, 1, 1'b1, '{4'h1, 4'h9, 4'hC, 4'h7, 8'd4}};
    vt[4] = '{16'h4E21, 2, 1'b0, '{4'h4, 4'hE, 4'h2, 4'h1, 8'd5}};
    vt[5] = '{16'h5BCD, 0, 1'b0, '{4'h5, 4'hB, 4'hC, 4'hD, 8'd6}};
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = 16'h0; dmem_done = 1'b0; start4 = 1'b0;
    tick(); tick();
    check_reset("rst0");
    rst_n = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    foreach (vt[i]) begin
      sb.push_back(vt[i].e);
      serve_fetch(vt[i].ins, vt[i].dly, 8'(i));
      wait_exec(3 + vt[i].dly, vt[i].dmem);
    end
    // LOAD held in MEMWAIT until dmem_done arrives three cycles after EXEC
    sb.push_back('{4'h0, 4'h3, 4'h1, 4'h0, 8'd7});
    serve_fetch(16'h0310, 0, 8'd6);
    wait_exec(3, 1'b0);
    chk("mw_op1", 32'({opcode, imem_req, exec_valid}), 32'h0);
    tick();
    chk("mw_op2", 32'({opcode, imem_req, exec_valid}), 32'h0);
    tick();
    chk("mw_op3", 32'({opcode, imem_req, exec_valid}), 32'h0);
    dmem_done = 1'b1; tick(); dmem_done = 1'b0;
    chk("mw_refetch", 32'({imem_req, exec_valid}), 32'h2);
    sb.push_back('{4'h2, 4'hA, 4'hB, 4'hC, 8'd8});
    serve_fetch(16'h2ABC, 5, 8'd7);
    wait_exec(8, 1'b0);
    serve_fetch(16'hF000, 0, 8'd8);
    tick();
    chk("halt_state", 32'({halted, imem_req, exec_valid, illegal}), 32'h8);
    chk("halt_opcode", 32'(opcode), 32'hF);
    for (int i = 0; i < 4; i++) begin
      start = (i == 0);
      tick();
      start = 1'b0;
      chk("halt_hold", 32'({halted, imem_req, exec_valid}), 32'h4);
      chk("halt_pc", 32'(pc), 32'd9);
    end
    rst_n = 1'b0; tick(); check_reset("rst1"); rst_n = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    serve_fetch(16'h7000, 0, 8'd0);
    tick();
    chk("illegal_flags", 32'({illegal, halted, exec_valid, imem_req}), 32'hC);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("illegal_hold", 32'({illegal, halted, exec_valid}), 32'h6);
    end
    rst_n = 1'b0; tick(); check_reset("rst2"); rst_n = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    sb.push_back('{4'h0, 4'h3, 4'h1, 4'h0, 8'd1});
    serve_fetch(16'h0310, 0, 8'd0);
    wait_exec(3, 1'b0);
    rst_n = 1'b0; tick(); check_reset("rst_memwait"); rst_n = 1'b1;
    start4 = 1'b1; tick(); start4 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin
      prev = pc4;
      tick();
      if (prev == 4'hF && pc4 != 4'hF) begin
        chk("pc_wrap", 32'(pc4), 32'h0);
        seen = 1'b1;
      end
    end
    chk("wrap_seen", 32'(seen), 32'h1);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
